// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- RV32I instruction-fetch stage
//
// Holds the PC, drives the asynchronous instruction-memory read address and
// owns the IF/ID pipeline register. It applies stall, flush and taken-branch
// redirects. It also spots the halt idiom (jal x0,0), lets the instructions
// already in flight drain, and then raises `halted`.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   pc_write        1 = PC may advance, 0 = hold (load-use stall)
//   if_id_write     1 = IF/ID may load, 0 = hold
//   flush           hazard flush, IF/ID becomes a bubble
//   take_branch     EX resolved a taken branch/jump to branch_target
//   branch_target   redirect address (low two bits ignored)
//   imem_addr       instruction-memory address (== if_pc)
//   imem_rdata      instruction word at imem_addr (async read)
//   if_pc/if_instr  current fetch PC and word
//   if_id_*         IF/ID register contents, valid = 0 marks a bubble
//   halt_pending    draining after a halt was seen
//   halted          drain complete, fetch frozen until reset
//   fetch_count     valid instructions loaded into IF/ID (wraps)
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR   = 32'h0000_006f,
    parameter int unsigned DRAIN_CYCLES = 4,              // legal range 1..15
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        flush,
    input  logic        take_branch,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halt_pending,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        halt_pending_q, halt_pending_d;
    logic        halted_q, halted_d;

    logic        halt_det;
    logic        bubble;
    logic [31:0] target_aligned;

    // Fetch path is purely combinational.
    assign imem_addr = pc_q;
    assign if_pc     = pc_q;
    assign if_instr  = imem_rdata;

    // The redirect target is always forced to a word boundary.
    assign target_aligned = branch_target & 32'hFFFF_FFFC;

    // A halt word only counts when it would really have been consumed: not
    // under a stall, not on a wrong path (branch/flush), and only once.
    assign halt_det = (state_q == S_RUN) && (imem_rdata == HALT_INSTR) &&
                      !take_branch && !flush && pc_write && if_id_write;

    // Any of these make IF/ID a bubble; the halt word never reaches ID.
    assign bubble = flush || take_branch || (state_q != S_RUN) || halt_det;

    // ---------------------------------------------------------------- next PC
    always_comb begin
        pc_d = pc_q;
        if (take_branch && (state_q != S_HALTED)) begin
            // Branch is older than any stall or pending halt, so it wins.
            pc_d = target_aligned;
        end else if ((state_q != S_RUN) || halt_det) begin
            pc_d = pc_q;
        end else if (!pc_write) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    // ------------------------------------------------------------------ IF/ID
    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        fetch_count_d = fetch_count_q;
        if (bubble) begin
            if_id_pc_d    = 32'd0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (if_id_write) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // -------------------------------------------------------------- halt FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (halt_det) begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_INIT;
                end
            end
            S_DRAIN: begin
                if (take_branch) begin
                    // Halt was fetched down a wrong path; resume normally.
                    state_d = S_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_HALTED;
                    end
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = 4'd0;
            end
        endcase
        // Status flags mirror the next state so they are registered outputs.
        halt_pending_d = (state_d == S_DRAIN);
        halted_d       = (state_d == S_HALTED);
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_RUN;
            cnt_q          <= 4'd0;
            pc_q           <= RESET_PC;
            if_id_pc_q     <= 32'd0;
            if_id_instr_q  <= NOP_INSTR;
            if_id_valid_q  <= 1'b0;
            fetch_count_q  <= 32'd0;
            halt_pending_q <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pc_q           <= pc_d;
            if_id_pc_q     <= if_id_pc_d;
            if_id_instr_q  <= if_id_instr_d;
            if_id_valid_q  <= if_id_valid_d;
            fetch_count_q  <= fetch_count_d;
            halt_pending_q <= halt_pending_d;
            halted_q       <= halted_d;
        end
    end

    assign if_id_pc     = if_id_pc_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_valid  = if_id_valid_q;
    assign fetch_count  = fetch_count_q;
    assign halt_pending = halt_pending_q;
    assign halted       = halted_q;

endmodule
